// File: rtl/pcie_msi_irq_pkg.sv
// pcie_msi_irq_pkg: shared state type and constants for the MSI interrupt block
package pcie_msi_irq_pkg;
    localparam int MSI_VEC_W = 32;
    localparam int MMEN_MAX = 5;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;
endpackage

// File: rtl/pcie_msi_irq_rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N = 32,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);
    int s;
    logic [IW-1:0] j;
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        s = 0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            j = IW'(s >= N ? s - N : s);
            if (req[j]) begin
                gnt_idx = j;
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcie_msi_irq.sv
// pcie_msi_irq: edge-triggered IRQ inputs to one-hot MSI strobes with retry/backoff.
// Define PCIE_MSI_IRQ_STATS_EN to add saturating sent/fail counters.
module pcie_msi_irq
    import pcie_msi_irq_pkg::*;
#(
    parameter int IRQ_COUNT = 32,
    parameter int WAIT_TIMEOUT = 1024,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IRQ_COUNT-1:0] irq_req,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    output logic [31:0]          cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [3:0]           cfg_interrupt_msi_select,
    output logic [3:0]           cfg_interrupt_msi_function_number,
    output logic [2:0]           cfg_interrupt_msi_attr,
    output logic                 cfg_interrupt_msi_tph_present,
    output logic [1:0]           cfg_interrupt_msi_tph_type,
    output logic [8:0]           cfg_interrupt_msi_tph_st_tag,
    output logic [31:0]          cfg_interrupt_msi_pending_status,
    output logic                 cfg_interrupt_msi_pending_status_data_enable,
    output logic [3:0]           cfg_interrupt_msi_pending_status_function_num,
`ifdef PCIE_MSI_IRQ_STATS_EN
    output logic [31:0]          stat_sent_cnt,
    output logic [31:0]          stat_fail_cnt,
`endif
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic                 irq_busy
);
    localparam int IW = IRQ_COUNT > 1 ? $clog2(IRQ_COUNT) : 1;
    localparam int CMAX = WAIT_TIMEOUT > BACKOFF_CYCLES ? WAIT_TIMEOUT : BACKOFF_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    state_t state, state_nxt;
    logic [IRQ_COUNT-1:0] irq_req_q, pending, edges, clr, rearm;
    logic [IW-1:0] ptr, gnt_idx, idx_q;
    logic gnt_vld, take, sent_ok, fail_ev, timeout, bo_done;
    logic [4:0] vec_q, mask;
    logic [2:0] mm;
    logic [CW-1:0] cnt;
    logic unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};
    assign edges = irq_req & ~irq_req_q;
    assign mm = cfg_interrupt_msi_mmenable[2:0] > 3'(MMEN_MAX) ? 3'(MMEN_MAX) : cfg_interrupt_msi_mmenable[2:0];
    assign mask = 5'((6'd1 << mm) - 6'd1);
    assign take = state == IDLE && cfg_interrupt_msi_enable[0] && gnt_vld;
    assign timeout = cnt == CW'(WAIT_TIMEOUT - 1);
    assign bo_done = cnt == CW'(BACKOFF_CYCLES - 1);
    // fail beats sent; a sent arriving in the last timeout cycle still counts
    assign fail_ev = state == WAIT && (cfg_interrupt_msi_fail || (timeout && !cfg_interrupt_msi_sent));
    assign sent_ok = state == WAIT && cfg_interrupt_msi_sent && !cfg_interrupt_msi_fail;
    assign clr = take ? IRQ_COUNT'(1) << gnt_idx : '0;
    assign rearm = fail_ev ? IRQ_COUNT'(1) << idx_q : '0;

    rr_arbiter #(.N(IRQ_COUNT), .IW(IW)) u_arb (
        .req(pending),
        .ptr(ptr),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state == IDLE ? (take ? ISSUE : IDLE) :
                    state == ISSUE ? WAIT :
                    state == WAIT ? (fail_ev ? BACKOFF : sent_ok ? IDLE : WAIT) :
                    (bo_done ? IDLE : BACKOFF);
    end

    always_comb begin
        cfg_interrupt_msi_int = state == ISSUE ? MSI_VEC_W'(1) << vec_q : '0;
        irq_busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            irq_req_q <= '0;
            pending <= '0;
            ptr <= '0;
            idx_q <= '0;
            vec_q <= '0;
            cnt <= '0;
        end else begin
            irq_req_q <= irq_req;
            pending <= (pending & ~clr) | rearm | edges;
            cnt <= (state == IDLE || state_nxt != state) ? '0 : cnt + 1'b1;
            if (take) begin
                idx_q <= gnt_idx;
                vec_q <= 5'(gnt_idx) & mask;
            end
            if (sent_ok) ptr <= idx_q == IW'(IRQ_COUNT - 1) ? '0 : idx_q + 1'b1;
        end

`ifdef PCIE_MSI_IRQ_STATS_EN
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            stat_sent_cnt <= '0;
            stat_fail_cnt <= '0;
        end else begin
            if (sent_ok && ~&stat_sent_cnt) stat_sent_cnt <= stat_sent_cnt + 1'b1;
            if (fail_ev && ~&stat_fail_cnt) stat_fail_cnt <= stat_fail_cnt + 1'b1;
        end
`endif

    assign irq_pending = pending;
    assign cfg_interrupt_msi_select = '0;
    assign cfg_interrupt_msi_function_number = '0;
    assign cfg_interrupt_msi_attr = '0;
    assign cfg_interrupt_msi_tph_present = 1'b0;
    assign cfg_interrupt_msi_tph_type = '0;
    assign cfg_interrupt_msi_tph_st_tag = '0;
    assign cfg_interrupt_msi_pending_status = '0;
    assign cfg_interrupt_msi_pending_status_data_enable = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num = '0;
endmodule

// File: tb/tb_pcie_msi_irq.sv
// tb_pcie_msi_irq: directed scenarios for pcie_msi_irq with default parameters
module tb_pcie_msi_irq;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [31:0] irq_req = '0;
    logic [3:0] en = '0;
    logic [11:0] mmen = 12'd5;
    logic sent = 1'b0, fail = 1'b0;
    logic [31:0] msi_int, pending;
    logic busy;
    logic [3:0] sel, fn, psfn;
    logic [2:0] attr;
    logic tph_p, psde;
    logic [1:0] tph_t;
    logic [8:0] tag;
    logic [31:0] ps;
`ifdef PCIE_MSI_IRQ_STATS_EN
    logic [31:0] st_sent, st_fail;
    int exp_sent = 0;
`endif
    int checks = 0;
    int failures = 0;
    logic [31:0] v;
    int n;

    pcie_msi_irq dut (
        .clk(clk),
        .rstn(rstn),
        .irq_req(irq_req),
        .cfg_interrupt_msi_enable(en),
        .cfg_interrupt_msi_mmenable(mmen),
        .cfg_interrupt_msi_int(msi_int),
        .cfg_interrupt_msi_sent(sent),
        .cfg_interrupt_msi_fail(fail),
        .cfg_interrupt_msi_select(sel),
        .cfg_interrupt_msi_function_number(fn),
        .cfg_interrupt_msi_attr(attr),
        .cfg_interrupt_msi_tph_present(tph_p),
        .cfg_interrupt_msi_tph_type(tph_t),
        .cfg_interrupt_msi_tph_st_tag(tag),
        .cfg_interrupt_msi_pending_status(ps),
        .cfg_interrupt_msi_pending_status_data_enable(psde),
        .cfg_interrupt_msi_pending_status_function_num(psfn),
`ifdef PCIE_MSI_IRQ_STATS_EN
        .stat_sent_cnt(st_sent),
        .stat_fail_cnt(st_fail),
`endif
        .irq_pending(pending),
        .irq_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_pulse(input int max, output logic [31:0] pv, output int pn);
        pv = '0;
        pn = 0;
        while (pn < max && pv == 0) begin
            @(negedge clk);
            pn++;
            pv = msi_int;
        end
    endtask

    task automatic send(input int k);
        repeat (k) @(negedge clk);
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
`ifdef PCIE_MSI_IRQ_STATS_EN
        exp_sent++;
`endif
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (msi_int !== 0) begin failures++; $display("FAIL reset_int got=%h exp=0", msi_int); end
        checks++; if (pending !== 0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
        checks++; if (busy !== 0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({sel, fn, attr, tph_p, tph_t, tag, ps, psde, psfn} !== '0) begin failures++; $display("FAIL const_zero got nonzero exp=0"); end
`ifdef PCIE_MSI_IRQ_STATS_EN
        checks++; if ({st_sent, st_fail} !== '0) begin failures++; $display("FAIL reset_stats got=%h/%h exp=0/0", st_sent, st_fail); end
`endif
        rstn = 1'b1;
        en = 4'h1;
        @(negedge clk);
    endtask

    task automatic test_single;
        irq_req[3] = 1'b1;
        @(negedge clk);
        checks++; if (pending !== 32'h8) begin failures++; $display("FAIL single_pend got=%h exp=8", pending); end
        checks++; if (msi_int !== 0) begin failures++; $display("FAIL single_early got=%h exp=0", msi_int); end
        @(negedge clk);
        checks++; if (msi_int !== 32'h8) begin failures++; $display("FAIL single_vec got=%h exp=8", msi_int); end
        checks++; if (pending !== 0) begin failures++; $display("FAIL single_clr got=%h exp=0", pending); end
        @(negedge clk);
        checks++; if (msi_int !== 0 || busy !== 1) begin failures++; $display("FAIL single_1cyc got=%h/%b exp=0/1", msi_int, busy); end
        send(3);
        checks++; if (busy !== 0 || pending !== 0) begin failures++; $display("FAIL single_done got=%b/%h exp=0/0", busy, pending); end
        irq_req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        for (int b = 0; b < 2; b++) begin
            irq_req[2:0] = 3'b111;
            for (int i = 0; i < 3; i++) begin
                wait_pulse(10, v, n);
                checks++; if (v !== (32'h1 << i)) begin failures++; $display("FAIL rr_order burst=%0d got=%h exp=%h", b, v, 32'h1 << i); end
                if (i == 0) begin
                    checks++; if (n !== 2) begin failures++; $display("FAIL rr_latency got=%0d exp=2", n); end
                end
                send(2);
            end
            irq_req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        irq_req[2] = 1'b1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL to_vec got=%h exp=4", v); end
        repeat (1024) @(negedge clk);
        checks++; if (busy !== 1 || pending !== 0) begin failures++; $display("FAIL to_wait got=%b/%h exp=1/0", busy, pending); end
        @(negedge clk);
        checks++; if (pending !== 32'h4) begin failures++; $display("FAIL to_repend got=%h exp=4", pending); end
        wait_pulse(40, v, n);
        checks++; if (v !== 32'h4 || n !== 17) begin failures++; $display("FAIL to_reissue got=%h@%0d exp=4@17", v, n); end
        send(1);
        irq_req = '0;
`ifdef PCIE_MSI_IRQ_STATS_EN
        checks++; if (st_fail !== 1) begin failures++; $display("FAIL to_stat got=%0d exp=1", st_fail); end
`endif
        @(negedge clk);
    endtask

    task automatic test_fail_retry;
        irq_req[7] = 1'b1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h80) begin failures++; $display("FAIL fr_vec got=%h exp=80", v); end
        @(negedge clk);
        fail = 1'b1;
        @(negedge clk);
        fail = 1'b0;
        checks++; if (pending !== 32'h80 || busy !== 1) begin failures++; $display("FAIL fr_repend got=%h/%b exp=80/1", pending, busy); end
        wait_pulse(40, v, n);
        checks++; if (v !== 32'h80 || n !== 17) begin failures++; $display("FAIL fr_reissue got=%h@%0d exp=80@17", v, n); end
        @(negedge clk);
        sent = 1'b1;
        fail = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        fail = 1'b0;
        checks++; if (pending !== 32'h80) begin failures++; $display("FAIL fr_failwins got=%h exp=80", pending); end
        wait_pulse(40, v, n);
        checks++; if (v !== 32'h80) begin failures++; $display("FAIL fr_third got=%h exp=80", v); end
        send(1);
        checks++; if (pending !== 0 || busy !== 0) begin failures++; $display("FAIL fr_done got=%h/%b exp=0/0", pending, busy); end
        irq_req = '0;
        @(negedge clk);
    endtask

    task automatic test_disable;
        en = 4'h0;
        irq_req[4] = 1'b1;
        @(negedge clk);
        irq_req[4] = 1'b0;
        @(negedge clk);
        irq_req[5:4] = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (pending !== 32'h30 || busy !== 0) begin failures++; $display("FAIL dis_hold got=%h/%b exp=30/0", pending, busy); end
        wait_pulse(20, v, n);
        checks++; if (v !== 0) begin failures++; $display("FAIL dis_nopulse got=%h exp=0", v); end
        en = 4'h1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h10) begin failures++; $display("FAIL dis_first got=%h exp=10", v); end
        @(negedge clk);
        en = 4'h0;
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
`ifdef PCIE_MSI_IRQ_STATS_EN
        exp_sent++;
`endif
        checks++; if (busy !== 0 || pending !== 32'h20) begin failures++; $display("FAIL dis_waitdone got=%b/%h exp=0/20", busy, pending); end
        wait_pulse(20, v, n);
        checks++; if (v !== 0) begin failures++; $display("FAIL dis_held got=%h exp=0", v); end
        en = 4'h1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h20) begin failures++; $display("FAIL dis_second got=%h exp=20", v); end
        send(1);
        wait_pulse(30, v, n);
        checks++; if (v !== 0) begin failures++; $display("FAIL coalesce got=%h exp=0", v); end
        irq_req = '0;
`ifdef PCIE_MSI_IRQ_STATS_EN
        checks++; if (st_sent !== 32'(exp_sent) || st_fail !== 3) begin failures++; $display("FAIL stats got=%0d/%0d exp=%0d/3", st_sent, st_fail, exp_sent); end
`endif
        @(negedge clk);
    endtask

    task automatic test_fold;
        logic [2:0] mms [3] = '{3'd2, 3'd7, 3'd0};
        logic [31:0] exps [3] = '{32'h2, 32'h2000, 32'h1};
        for (int i = 0; i < 3; i++) begin
            mmen = {9'd0, mms[i]};
            irq_req[13] = 1'b1;
            wait_pulse(10, v, n);
            checks++; if (v !== exps[i]) begin failures++; $display("FAIL fold mm=%0d got=%h exp=%h", mms[i], v, exps[i]); end
            send(1);
            irq_req = '0;
            @(negedge clk);
        end
        mmen = 12'd5;
    endtask

    task automatic test_reset_mid;
        irq_req[9] = 1'b1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h200) begin failures++; $display("FAIL rst_vec got=%h exp=200", v); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (msi_int !== 0 || busy !== 0 || pending !== 0) begin failures++; $display("FAIL rst_async got=%h/%b/%h exp=0/0/0", msi_int, busy, pending); end
        irq_req = '0;
        @(negedge clk);
        rstn = 1'b1;
        wait_pulse(40, v, n);
        checks++; if (v !== 0) begin failures++; $display("FAIL rst_noretry got=%h exp=0", v); end
        rstn = 1'b0;
        irq_req[1] = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        wait_pulse(10, v, n);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL rst_highin got=%h exp=2", v); end
        send(1);
        irq_req = '0;
`ifdef PCIE_MSI_IRQ_STATS_EN
        checks++; if (st_sent !== 1 || st_fail !== 0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=1/0", st_sent, st_fail); end
`endif
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_fail_retry;
        test_disable;
        test_fold;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
